// File: rtl/store_unit_ctrl_if.sv
// Store unit types and bus interface.
//   store_unit_ctrl_pkg : store_kind_t, the decoded store kind from execute.
//   store_unit_ctrl_if  : execute-side request channel, data-memory write
//                         channel and completion/status signals.
//                         slave  = store unit view, master = requester/memory view.
package store_unit_ctrl_pkg;
  typedef enum logic [1:0] {
    sk_sb      = 2'd0,
    sk_sh      = 2'd1,
    sk_sw      = 2'd2,
    sk_invalid = 2'd3
  } store_kind_t;
endpackage

interface store_unit_ctrl_if;
  import store_unit_ctrl_pkg::*;

  logic        start_valid;
  logic        start_ready;
  store_kind_t kind;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        done;
  logic        err;
  logic [1:0]  err_cause;

  modport slave (
    input  start_valid, kind, addr, wdata, mem_ack,
    output start_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err, err_cause
  );

  modport master (
    output start_valid, kind, addr, wdata, mem_ack,
    input  start_ready, mem_req, mem_addr, mem_wdata, mem_be, done, err, err_cause
  );
endinterface

// File: rtl/store_unit_ctrl.sv
// Store unit controller: accepts one SB/SH/SW store at a time, checks
// legality, positions data/byte enables on the word lanes and issues a single
// data-memory write, then pulses done (with err/err_cause on a rejected store).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : store_unit_ctrl_if.slave (request, memory write, status)
// Optional feature: define STORE_TIMEOUT_EN to abort a write with cause 11
// after TIMEOUT_CYCLES cycles in REQ without mem_ack.
module store_unit_ctrl
  import store_unit_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic         clk,
  input logic         rst,
  store_unit_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // A zero limit would abort every write before it could be acknowledged.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  state_t      state_q, state_d;
  logic        start_ready_q, start_ready_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_cause_q, err_cause_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_data;
  logic [1:0]  chk_cause;

`ifdef STORE_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Lane placement and legality of the incoming request; invalid kind wins.
  always_comb begin
    lane_be   = 4'b0000;
    lane_data = 32'h0;
    chk_cause = CAUSE_NONE;
    case (bus.kind)
      sk_sb: begin
        lane_be   = 4'b0001 << bus.addr[1:0];
        lane_data = {4{bus.wdata[7:0]}};
      end
      sk_sh: begin
        lane_be   = 4'b0011 << {bus.addr[1], 1'b0};
        lane_data = {2{bus.wdata[15:0]}};
        if (bus.addr[0]) chk_cause = CAUSE_MISALIGN;
      end
      sk_sw: begin
        lane_be   = 4'b1111;
        lane_data = bus.wdata;
        if (bus.addr[1:0] != 2'b00) chk_cause = CAUSE_MISALIGN;
      end
      default: chk_cause = CAUSE_ILLEGAL;
    endcase
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = 4'b0000;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_cause_d = CAUSE_NONE;
`ifdef STORE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          if (chk_cause == CAUSE_NONE) begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_addr_d  = {bus.addr[31:2], 2'b00};
            mem_wdata_d = lane_data;
            mem_be_d    = lane_be;
`ifdef STORE_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            state_d     = ERR;
            done_d      = 1'b1;
            err_d       = 1'b1;
            err_cause_d = chk_cause;
          end
        end
      end
      REQ: begin
        mem_req_d = 1'b1;
        mem_be_d  = mem_be_q;
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_be_d  = 4'b0000;
          done_d    = 1'b1;
`ifdef STORE_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ERR;
          mem_req_d   = 1'b0;
          mem_be_d    = 4'b0000;
          done_d      = 1'b1;
          err_d       = 1'b1;
          err_cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    start_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      start_ready_q <= 1'b1;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      mem_be_q      <= 4'b0000;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_cause_q   <= CAUSE_NONE;
    end else begin
      state_q       <= state_d;
      start_ready_q <= start_ready_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_be_q      <= mem_be_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_cause_q   <= err_cause_d;
    end
  end

`ifdef STORE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign bus.start_ready = start_ready_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_be      = mem_be_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.err_cause   = err_cause_q;

endmodule
